// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Takes a 16-bit big-endian word count and then a big-endian stream of
// 32-bit words over a valid/ready handshake. Each word is written to
// consecutive word addresses through one write port. busy holds the core
// in reset while a load is running.
// Optional feature: define CHECKSUM_EN to have the loader accept one trailing
// checksum byte and compare it with the XOR of all payload bytes.
module imem_loader #(
  parameter int unsigned n      = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [n-1:0]      mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [31:0] CAP = 32'(1) << ADDR_W;

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_BYTES, S_WRITE, S_CHK, S_DONE
  } state_e;
  localparam state_e S_FIN = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_BYTES, S_WRITE, S_DONE
  } state_e;
  localparam state_e S_FIN = S_DONE;
`endif

  state_e              state_q, state_d;
  logic [15:0]         len_q;
  logic [23:0]         word_q;
  logic [1:0]          bcnt_q;
  logic [ADDR_W-1:0]   widx_q;
  logic [ADDR_W:0]     wl_q;
  logic                in_ready_q, mem_we_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [n-1:0]        mem_wdata_q;
`ifdef CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic        xfer;
  logic [15:0] len_full;
  logic        len_zero, len_over, last_word;

  assign xfer      = in_valid & in_ready_q;
  assign len_full  = {len_q[15:8], in_data};
  assign len_zero  = (len_full == 16'd0);
  assign len_over  = (32'(len_full) > CAP);
  assign last_word = ((32'(wl_q) + 32'd1) == 32'(len_q));

  function automatic logic busy_of(state_e s);
    case (s)
      S_LEN_HI, S_LEN_LO, S_BYTES, S_WRITE: return 1'b1;
`ifdef CHECKSUM_EN
      S_CHK:                                return 1'b1;
`endif
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic ready_of(state_e s);
    case (s)
      S_LEN_HI, S_LEN_LO, S_BYTES: return 1'b1;
`ifdef CHECKSUM_EN
      S_CHK:                       return 1'b1;
`endif
      default:                     return 1'b0;
    endcase
  endfunction

  // Next-state selection; outputs are then registered from the chosen state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LEN_HI;
      S_LEN_HI:       if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_over)      state_d = S_DONE;
          else if (len_zero) state_d = S_FIN;
          else               state_d = S_BYTES;
        end
      end
      S_BYTES:        if (xfer && bcnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE:        state_d = last_word ? S_FIN : S_BYTES;
`ifdef CHECKSUM_EN
      S_CHK:          if (xfer) state_d = S_DONE;
`endif
      default:        state_d = S_IDLE;
    endcase
  end

  // FSM state, registered outputs and load datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_q      <= '0;
      bcnt_q      <= '0;
      widx_q      <= '0;
      wl_q        <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_of(state_d);
      in_ready_q <= ready_of(state_d);
      done_q     <= (state_d == S_DONE);
      mem_we_q   <= (state_d == S_WRITE);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_q  <= 1'b0;
            wl_q   <= '0;
            widx_q <= '0;
            bcnt_q <= '0;
            len_q  <= '0;
            word_q <= '0;
`ifdef CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        S_LEN_HI: if (xfer) len_q[15:8] <= in_data;
        S_LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= in_data;
            if (len_over) err_q <= 1'b1;
          end
        end
        S_BYTES: begin
          if (xfer) begin
            word_q <= {word_q[15:0], in_data};
            bcnt_q <= bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            // Write port is loaded while entering WRITE so it is valid with mem_we.
            if (bcnt_q == 2'd3) begin
              mem_addr_q  <= widx_q;
              mem_wdata_q <= n'({word_q, in_data});
            end
          end
        end
        S_WRITE: begin
          widx_q <= widx_q + 1'b1;
          wl_q   <= wl_q + 1'b1;
        end
`ifdef CHECKSUM_EN
        S_CHK: if (xfer && in_data != csum_q) err_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
